// File: rtl/butterfly_mult_add_sched.sv
// Round-robin sequencer sharing one external 16-bit carry-chained adder between two
// wide-add requesters; each request runs one word per cycle, low word first.
module butterfly_mult_add_sched #(
    parameter int NWORDS = 2,
    parameter int IDXW   = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [16*NWORDS-1:0] a_op1,
    input  logic [16*NWORDS-1:0] a_op2,
    input  logic                 a_cin,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [16*NWORDS-1:0] b_op1,
    input  logic [16*NWORDS-1:0] b_op2,
    input  logic                 b_cin,
    output logic [15:0]          add_operand1,
    output logic [15:0]          add_operand2,
    output logic                 add_carryin,
    input  logic [15:0]          add_result,
    input  logic                 add_carry_out,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [16*NWORDS-1:0] res_sum,
    output logic                 res_carry,
    output logic                 res_tag,
    output logic                 busy
);

    localparam int W = 16 * NWORDS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [IDXW-1:0] idx_r;
    logic            carry_r;
    logic [W-1:0]    op1_r;
    logic [W-1:0]    op2_r;
    logic [W-1:0]    res_sum_r;
    logic            res_carry_r;
    logic            res_tag_r;
    logic            last_grant_r;
    logic            grant_a_s;
    logic            grant_b_s;
    logic            last_word_s;

    // Selects 16-bit word i of a wide operand without a variable part-select.
    function automatic logic [15:0] word_sel(input logic [W-1:0] v, input logic [IDXW-1:0] i);
        logic [15:0] w;
        w = 16'h0000;
        for (int k = 0; k < NWORDS; k++) begin
            w = w | (v[k*16 +: 16] & {16{i == IDXW'(k)}});
        end
        return w;
    endfunction

    assign last_word_s = (idx_r == IDXW'(NWORDS - 1));

    // Grant arbitration: single requester wins outright, a tie goes to the one not served last.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (state_r == IDLE && reset_n) begin
            if (a_valid && b_valid) begin
                grant_a_s = last_grant_r;
                grant_b_s = ~last_grant_r;
            end else begin
                grant_a_s = a_valid;
                grant_b_s = b_valid;
            end
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_a_s || grant_b_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_word_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Adder drive: current word and chained carry while running, quiet otherwise.
    always_comb begin
        add_operand1 = 16'h0000;
        add_operand2 = 16'h0000;
        add_carryin  = 1'b0;
        if (state_r == RUN) begin
            add_operand1 = word_sel(op1_r, idx_r);
            add_operand2 = word_sel(op2_r, idx_r);
            add_carryin  = carry_r;
        end else begin
            add_operand1 = 16'h0000;
            add_operand2 = 16'h0000;
            add_carryin  = 1'b0;
        end
    end

    // State, operand capture and word-serial result accumulation.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            idx_r        <= '0;
            carry_r      <= 1'b0;
            op1_r        <= '0;
            op2_r        <= '0;
            res_sum_r    <= '0;
            res_carry_r  <= 1'b0;
            res_tag_r    <= 1'b0;
            last_grant_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                IDLE: begin
                    if (grant_a_s || grant_b_s) begin
                        op1_r        <= grant_b_s ? b_op1 : a_op1;
                        op2_r        <= grant_b_s ? b_op2 : a_op2;
                        carry_r      <= grant_b_s ? b_cin : a_cin;
                        res_tag_r    <= grant_b_s;
                        last_grant_r <= grant_b_s;
                        idx_r        <= '0;
                    end
                end
                RUN: begin
                    for (int k = 0; k < NWORDS; k++) begin
                        if (idx_r == IDXW'(k)) begin
                            res_sum_r[k*16 +: 16] <= add_result;
                        end
                    end
                    carry_r <= add_carry_out;
                    if (last_word_s) begin
                        res_carry_r <= add_carry_out;
                        idx_r       <= '0;
                    end else begin
                        idx_r <= idx_r + IDXW'(1);
                    end
                end
                DONE: begin
                    idx_r <= '0;
                end
                default: begin
                    idx_r <= '0;
                end
            endcase
        end
    end

    assign a_ready   = grant_a_s;
    assign b_ready   = grant_b_s;
    assign res_valid = (state_r == DONE);
    assign busy      = (state_r != IDLE);
    assign res_sum   = res_sum_r;
    assign res_carry = res_carry_r;
    assign res_tag   = res_tag_r;

endmodule

// File: tb/tb_butterfly_mult_add_sched.sv
// Self-checking bench for butterfly_mult_add_sched: directed vector table, corner
// sequences (backpressure, mid-run reset, round-robin) and a randomised scoreboard run.
module tb_butterfly_mult_add_sched;

    localparam int NWORDS = 2;
    localparam int IDXW   = 3;
    localparam int W      = 16 * NWORDS;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         a_valid, a_ready, a_cin;
    logic [W-1:0] a_op1, a_op2;
    logic         b_valid, b_ready, b_cin;
    logic [W-1:0] b_op1, b_op2;
    logic [15:0]  add_operand1, add_operand2, add_result;
    logic         add_carryin, add_carry_out;
    logic         res_valid, res_ready, res_carry, res_tag, busy;
    logic [W-1:0] res_sum;

    typedef struct packed {
        logic         tag;
        logic         carry;
        logic [W-1:0] sum;
    } exp_t;

    typedef struct packed {
        logic         port;
        logic [W-1:0] op1;
        logic [W-1:0] op2;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_carry;
    } vec_t;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   res_count = 0;
    bit   sb_en = 1'b0;
    bit   rr_en = 1'b0;
    exp_t sb_q[$];
    logic tag_log[$];
    vec_t vecs[6];

    always #5 clk = ~clk;

    // Behavioural stand-in for the external 16-bit adder.
    assign {add_carry_out, add_result} = {1'b0, add_operand1} + {1'b0, add_operand2} + {16'h0000, add_carryin};

    butterfly_mult_add_sched #(.NWORDS(NWORDS), .IDXW(IDXW)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_op1(a_op1), .a_op2(a_op2), .a_cin(a_cin),
        .b_valid(b_valid), .b_ready(b_ready), .b_op1(b_op1), .b_op2(b_op2), .b_cin(b_cin),
        .add_operand1(add_operand1), .add_operand2(add_operand2), .add_carryin(add_carryin),
        .add_result(add_result), .add_carry_out(add_carry_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
        .res_carry(res_carry), .res_tag(res_tag), .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic tag, input logic [W-1:0] o1, input logic [W-1:0] o2, input logic c);
        exp_t e;
        logic [W:0] s;
        s = {1'b0, o1} + {1'b0, o2} + {{W{1'b0}}, c};
        e.tag   = tag;
        e.carry = s[W];
        e.sum   = s[W-1:0];
        return e;
    endfunction

    // Scoreboard monitor, sampling on the falling edge when inputs and outputs are settled.
    always @(negedge clk) begin
        if (a_ready || b_ready) begin
            check("ready_mutex", 64'(a_ready && b_ready), 64'd0);
        end
        if (sb_en && reset_n) begin
            if (a_valid && a_ready) sb_q.push_back(model(1'b0, a_op1, a_op2, a_cin));
            if (b_valid && b_ready) sb_q.push_back(model(1'b1, b_op1, b_op2, b_cin));
            if (res_valid && res_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_result", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sb_sum", 64'(res_sum), 64'(e.sum));
                    check("sb_carry", 64'(res_carry), 64'(e.carry));
                    check("sb_tag", 64'(res_tag), 64'(e.tag));
                end
                tag_log.push_back(res_tag);
                res_count++;
            end
        end
    end

    // Present a request on one port, hold it until accepted, then withdraw it.
    task automatic issue(input logic port, input logic [W-1:0] o1, input logic [W-1:0] o2,
                         input logic c, output bit ok);
        ok = 1'b0;
        if (port) begin
            b_op1 = o1; b_op2 = o2; b_cin = c; b_valid = 1'b1;
        end else begin
            a_op1 = o1; a_op2 = o2; a_cin = c; a_valid = 1'b1;
        end
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (port ? b_ready : a_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (port) b_valid = 1'b0;
        else      a_valid = 1'b0;
    endtask

    // Wait for res_valid; lat counts cycles with the accept cycle as cycle 0.
    task automatic wait_result(output bit ok, output int lat);
        ok  = 1'b0;
        lat = 1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
            lat++;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        sb_q.delete();
        tag_log.delete();
        res_count = 0;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_a_ready"}, 64'(a_ready), 64'd0);
        check({tag, "_b_ready"}, 64'(b_ready), 64'd0);
        check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_add_ops"}, 64'({add_operand1, add_operand2, add_carryin}), 64'd0);
    endtask

    task automatic drive_random(input logic port, input int n);
        bit ok;
        logic [W-1:0] o1, o2;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            o1 = ($urandom_range(0, 3) == 0) ? {W{1'b1}} : W'($urandom);
            o2 = ($urandom_range(0, 3) == 0) ? {W{1'b0}} : W'($urandom);
            issue(port, o1, o2, 1'($urandom_range(0, 1)), ok);
            check("rand_accept", 64'(ok), 64'd1);
        end
    endtask

    initial begin
        bit ok;
        int lat;
        logic [W-1:0] hold_sum;
        logic hold_carry, hold_tag;

        vecs[0] = '{1'b0, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0};
        vecs[1] = '{1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
        vecs[2] = '{1'b0, 32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0};
        vecs[3] = '{1'b1, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
        vecs[4] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[5] = '{1'b1, 32'h0001FFFF, 32'h0000FFFF, 1'b0, 32'h0002FFFE, 1'b0};

        reset_n = 1'b0;
        a_valid = 1'b0; a_op1 = '0; a_op2 = '0; a_cin = 1'b0;
        b_valid = 1'b0; b_op1 = '0; b_op2 = '0; b_cin = 1'b0;
        res_ready = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_zero("rst");
        check("rst_res_sum", 64'({res_sum, res_carry, res_tag}), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_idle_zero("post_rst");
        @(posedge clk);
        #1;

        // Directed vector table, including latency of each transaction.
        for (int v = 0; v < 6; v++) begin
            issue(vecs[v].port, vecs[v].op1, vecs[v].op2, vecs[v].cin, ok);
            check("vec_accept", 64'(ok), 64'd1);
            wait_result(ok, lat);
            check("vec_valid", 64'(ok), 64'd1);
            check("vec_latency", 64'(lat), 64'(NWORDS + 1));
            check("vec_sum", 64'(res_sum), 64'(vecs[v].exp_sum));
            check("vec_carry", 64'(res_carry), 64'(vecs[v].exp_carry));
            check("vec_tag", 64'(res_tag), 64'(vecs[v].port));
            @(posedge clk);
            #1;
        end

        // Round-robin with both requesters permanently valid.
        do_reset();
        sb_en = 1'b1;
        a_op1 = 32'h1;  a_op2 = 32'h2;  a_cin = 1'b0;
        b_op1 = 32'h10; b_op2 = 32'h20; b_cin = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            if (res_count >= 4) break;
        end
        #1;
        a_valid = 1'b0; b_valid = 1'b0;
        check("rr_count", 64'(res_count >= 4), 64'd1);
        if (tag_log.size() >= 4) begin
            check("rr_order", 64'({tag_log[0], tag_log[1], tag_log[2], tag_log[3]}), 64'(4'b0101));
        end else begin
            check("rr_order_len", 64'(tag_log.size()), 64'd4);
        end
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (!busy && sb_q.size() == 0) break;
        end
        check("rr_drain", 64'(sb_q.size()), 64'd0);
        sb_en = 1'b0;
        @(posedge clk);
        #1;

        // Backpressure in DONE while A has another request pending.
        res_ready = 1'b0;
        issue(1'b0, 32'h00000005, 32'h00000007, 1'b0, ok);
        check("bp_accept", 64'(ok), 64'd1);
        a_op1 = 32'h11110000; a_op2 = 32'h0000FFFF; a_cin = 1'b1; a_valid = 1'b1;
        wait_result(ok, lat);
        check("bp_valid", 64'(ok), 64'd1);
        check("bp_sum", 64'(res_sum), 64'h0000000C);
        hold_sum = res_sum; hold_carry = res_carry; hold_tag = res_tag;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold", 64'({res_sum, res_carry, res_tag}), 64'({hold_sum, hold_carry, hold_tag}));
            check("bp_flags", 64'({res_valid, busy, a_ready}), 64'(3'b110));
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 64'(res_valid), 64'd1);
        @(negedge clk);
        check("bp_idle_accept", 64'({busy, a_ready}), 64'(2'b01));
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        wait_result(ok, lat);
        check("bp2_valid", 64'(ok), 64'd1);
        check("bp2_result", 64'({res_carry, res_tag, res_sum}), {30'd0, 1'b0, 1'b0, 32'h11120000});
        @(posedge clk);
        #1;

        // Reset during the second RUN cycle abandons the transaction.
        issue(1'b0, 32'h0000FFFF, 32'h0000FFFF, 1'b1, ok);
        check("mr_accept", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_idle_zero("mr");
        @(posedge clk);
        #1;
        a_op1 = 32'h0000FFFF; a_op2 = 32'h0000FFFF; a_cin = 1'b1; a_valid = 1'b1;
        b_op1 = 32'h00000001; b_op2 = 32'h00000001; b_cin = 1'b0; b_valid = 1'b1;
        @(negedge clk);
        check("mr_grant_a", 64'({a_ready, b_ready}), 64'(2'b10));
        @(posedge clk);
        #1;
        a_valid = 1'b0; b_valid = 1'b0;
        wait_result(ok, lat);
        check("mr_valid", 64'(ok), 64'd1);
        check("mr_result", 64'({res_carry, res_tag, res_sum}), {30'd0, 1'b0, 1'b0, 32'h0001FFFF});
        @(posedge clk);
        #1;

        // Randomised traffic through both ports with random consumer backpressure.
        do_reset();
        sb_en = 1'b1;
        rr_en = 1'b1;
        fork
            begin
                while (rr_en) begin
                    @(posedge clk);
                    #1;
                    res_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        fork
            drive_random(1'b0, 500);
            drive_random(1'b1, 500);
        join
        rr_en = 1'b0;
        @(posedge clk);
        #2;
        res_ready = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (!busy && sb_q.size() == 0) break;
        end
        check("rand_drain", 64'(sb_q.size()), 64'd0);
        check("rand_count", 64'(res_count), 64'd1000);
        sb_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/butterfly_mult_add_sched.md
Name: butterfly_mult_add_sched

Overview:
- Sequencer and arbiter that time-shares one external 16-bit carry-chained adder (Butterfly_Mult_CLA16) between two requesters.
- Each request is a wide add of NWORDS x 16 bits, executed one 16-bit word per cycle, low word first. The carry is registered between words.
- Sits beside the multiplier's final-adder stage, so that partial-product accumulation and rounding logic can share a single adder instance.

Parameters:
- NWORDS, 2, number of 16-bit words per operand (operand width W = 16*NWORDS); legal range 1..8.
- IDXW, 3, width of the word-index counter; must satisfy 2^IDXW >= NWORDS.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- a_valid  in  1  requester A has an operation pending.
- a_ready  out  1  requester A's operation is accepted this cycle.
- a_op1  in  W  requester A operand 1.
- a_op2  in  W  requester A operand 2.
- a_cin  in  1  requester A carry-in.
- b_valid, b_ready, b_op1, b_op2, b_cin: same as the A ports, for requester B.
- add_operand1  out  16  to the adder's operand1.
- add_operand2  out  16  to the adder's operand2.
- add_carryin  out  1  to the adder's carryin.
- add_result  in  16  from the adder's result (combinational path).
- add_carry_out  in  1  from the adder's carry_out.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_sum  out  W  wide sum.
- res_carry  out  1  final carry-out.
- res_tag  out  1  0 = requester A, 1 = requester B.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (reset_n low at an edge) sets:
  - state = IDLE; idx = 0; carry register = 0; res_sum = 0; res_carry = 0; res_tag = 0; last_grant = 1 (B).
  - All outputs read 0: a_ready, b_ready, res_valid, busy, add_operand1, add_operand2, add_carryin.
- Reset mid-operation abandons the transaction: no res_valid, no partial result is exposed.
- States: IDLE, RUN, DONE.

IDLE:
- Grant is combinational. If exactly one of a_valid or b_valid is high, that requester is granted.
- If both are high, grant the requester that is not last_grant (round-robin).
- The ready of the granted requester is high in the same cycle; the other ready stays 0. Both readies are 0 outside IDLE.
- On the accept edge:
  - Capture op1, op2 and cin into internal registers; the carry register takes cin.
  - res_tag and last_grant take the granted requester.
  - idx = 0; state goes to RUN.
- Requester inputs are don't-care after the accept edge.

RUN (exactly NWORDS cycles):
- add_operand1 = op1 word idx; add_operand2 = op2 word idx; add_carryin = carry register.
- At each edge: res_sum word idx takes add_result; the carry register takes add_carry_out; idx increments.
- When idx == NWORDS-1, the next state is DONE, res_carry takes add_carry_out, and idx goes back to 0.

DONE:
- res_valid = 1.
- res_sum, res_carry and res_tag are held stable until res_valid && res_ready at an edge; the state then returns to IDLE.
- No new accept happens during DONE. A request asserted during DONE is granted in the following IDLE cycle.

General rules:
- Adder outputs are driven to 0 outside RUN.
- Latency: res_valid rises NWORDS+1 cycles after the accept edge. Minimum issue interval is NWORDS+2 cycles.
- Arithmetic: {res_carry, res_sum} = op1 + op2 + cin, modulo 2^(W+1).
- res_sum bits are only guaranteed correct while res_valid is high.
- The requester that is not granted must hold valid and its data stable; the block never drops a pending request.

Test Plan:
- Carry between words (NWORDS=2): A issues op1=0x0000FFFF, op2=0x00000001, cin=0 -> res_sum=0x00010000, res_carry=0, res_tag=0, res_valid exactly 3 cycles after the accept edge.
- Full carry chain: B issues op1=0xFFFFFFFF, op2=0x00000000, cin=1 -> res_sum=0x00000000, res_carry=1, res_tag=1.
- Round-robin:
  - After reset, A and B both valid every cycle (A: 0x1+0x2, B: 0x10+0x20) -> order of results is A(0x3), B(0x30), A, B.
  - a_ready and b_ready are never high together.
- Backpressure: hold res_ready=0 for 5 cycles in DONE while a_valid is high -> res_sum, res_carry and res_tag are stable, a_ready stays 0, busy=1. Raise res_ready -> IDLE next cycle, then A is accepted.
- Reset mid-RUN: pull reset_n low during the second RUN cycle -> next cycle all outputs are 0 and state is IDLE. A new request then completes correctly, and A wins if both requesters are valid.
- Randomised: 1000 random operand pairs and carry-ins through both ports with random res_ready -> every result equals the reference sum, and tags match the issuing requester.
